// File: rtl/sad_candidate_gen_if.sv
// Pixel beat stream into the SAD candidate generator.
// One current pixel plus eight reference lanes per beat.
interface sad_candidate_gen_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  cur_pix;
    logic [63:0] ref_pix;

    modport master (
        output in_valid,
        output cur_pix,
        output ref_pix,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  cur_pix,
        input  ref_pix,
        output in_ready
    );
endinterface

// File: rtl/sad_candidate_gen.sv
// Eight-lane SAD accumulator feeding the minimum-MAD compare stage.
// Sweeps a 16x16 candidate grid per block, 8 candidates per pass.
module sad_candidate_gen #(
    parameter int BLK_PIX   = 16,
    parameter int SAD_W     = 13,
    parameter int PASSES    = 32,
    parameter int FLUSH_CYC = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    sad_candidate_gen_if.slave  pix,
    output logic [20:0]         mad_1,
    output logic [20:0]         mad_2,
    output logic [20:0]         mad_3,
    output logic [20:0]         mad_4,
    output logic [20:0]         mad_5,
    output logic [20:0]         mad_6,
    output logic [20:0]         mad_7,
    output logic [20:0]         mad_8,
    output logic                compare_work,
    output logic                compare_refresh
);
    localparam int BW = $clog2(BLK_PIX + 1);
    localparam int FW = $clog2(FLUSH_CYC + 2);

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        PRESENT,
        FLUSH,
        REFRESH
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [BW-1:0]    beat;
    logic [4:0]       pass;
    logic [FW-1:0]    flush_cnt;
    logic [SAD_W-1:0] acc      [8];
    logic [SAD_W-1:0] acc_nxt  [8];
    logic [7:0]       diff     [8];
    logic [SAD_W:0]   sum      [8];
    logic [20:0]      mad_q    [8];

    logic xfer;
    logic last_beat;
    logic last_pass;

    assign xfer      = pix.in_valid && pix.in_ready;
    assign last_beat = xfer && (beat == BW'(BLK_PIX - 1));
    assign last_pass = (pass == 5'(PASSES - 1));

    // Saturating add: the carry into bit SAD_W pins the lane at all-ones
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            diff[k] = (pix.cur_pix > pix.ref_pix[8*k +: 8])
                    ? pix.cur_pix - pix.ref_pix[8*k +: 8]
                    : pix.ref_pix[8*k +: 8] - pix.cur_pix;
            sum[k] = {1'b0, acc[k]} + {{(SAD_W - 7){1'b0}}, diff[k]};
            acc_nxt[k] = sum[k][SAD_W] ? '1 : sum[k][SAD_W-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (last_beat) state_nxt = PRESENT;
            PRESENT: begin
                if (!last_pass)
                    state_nxt = ACCUM;
                else if (FLUSH_CYC == 0)
                    state_nxt = REFRESH;
                else
                    state_nxt = FLUSH;
            end
            FLUSH: begin
                if (flush_cnt == FW'(FLUSH_CYC - 1))
                    state_nxt = REFRESH;
            end
            REFRESH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy            = (state != IDLE);
    assign pix.in_ready    = (state == ACCUM);
    assign compare_work    = (state == PRESENT);
    assign compare_refresh = (state == REFRESH);
    assign done            = (state == REFRESH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            beat      <= '0;
            pass      <= '0;
            flush_cnt <= '0;
            for (int k = 0; k < 8; k++) begin
                acc[k]   <= '0;
                mad_q[k] <= '1;
            end
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        beat <= '0;
                        pass <= '0;
                        for (int k = 0; k < 8; k++)
                            acc[k] <= '0;
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        beat <= beat + 1'b1;
                        for (int k = 0; k < 8; k++)
                            acc[k] <= acc_nxt[k];
                    end
                    // Results land in the mad registers as PRESENT begins
                    if (last_beat) begin
                        for (int k = 0; k < 8; k++)
                            mad_q[k] <= {acc_nxt[k], pass[4:1],
                                         pass[0], 3'(k)};
                    end
                end
                PRESENT: begin
                    beat      <= '0;
                    flush_cnt <= '0;
                    for (int k = 0; k < 8; k++)
                        acc[k] <= '0;
                    if (!last_pass)
                        pass <= pass + 1'b1;
                end
                FLUSH:   flush_cnt <= flush_cnt + 1'b1;
                REFRESH: ;
                default: ;
            endcase
        end
    end

    assign mad_1 = mad_q[0];
    assign mad_2 = mad_q[1];
    assign mad_3 = mad_q[2];
    assign mad_4 = mad_q[3];
    assign mad_5 = mad_q[4];
    assign mad_6 = mad_q[5];
    assign mad_7 = mad_q[6];
    assign mad_8 = mad_q[7];
endmodule

// File: tb/tb_sad_candidate_gen.sv
// Directed bench for sad_candidate_gen: default 16-beat unit plus
// a 64-beat unit for the saturation case.
module tb_sad_candidate_gen;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        start_a, busy_a, done_a, work_a, refr_a;
    logic        start_b, busy_b, done_b, work_b, refr_b;
    logic [20:0] mad_a [1:8];
    logic [20:0] mad_b [1:8];

    sad_candidate_gen_if pa ();
    sad_candidate_gen_if pb ();

    sad_candidate_gen u_a (
        .clk(clk), .reset(reset), .start(start_a),
        .busy(busy_a), .done(done_a), .pix(pa.slave),
        .mad_1(mad_a[1]), .mad_2(mad_a[2]),
        .mad_3(mad_a[3]), .mad_4(mad_a[4]),
        .mad_5(mad_a[5]), .mad_6(mad_a[6]),
        .mad_7(mad_a[7]), .mad_8(mad_a[8]),
        .compare_work(work_a), .compare_refresh(refr_a)
    );

    sad_candidate_gen #(.BLK_PIX(64)) u_b (
        .clk(clk), .reset(reset), .start(start_b),
        .busy(busy_b), .done(done_b), .pix(pb.slave),
        .mad_1(mad_b[1]), .mad_2(mad_b[2]),
        .mad_3(mad_b[3]), .mad_4(mad_b[4]),
        .mad_5(mad_b[5]), .mad_6(mad_b[6]),
        .mad_7(mad_b[7]), .mad_8(mad_b[8]),
        .compare_work(work_b), .compare_refresh(refr_b)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] cur_of(int t, int p, int b);
        if (t == 1) return 8'd100;
        return 8'((b * 37 + p * 11) & 255);
    endfunction

    function automatic logic [7:0] ref_of(int t, int p, int b, int k);
        if (t == 1) return (p == 5 && k == 4) ? 8'd100 : 8'd101;
        return 8'((b * 53 + k * 29 + p * 5 + 17) & 255);
    endfunction

    function automatic logic [20:0] exp_mad(int t, int p, int k);
        int s;
        int c;
        int r;
        logic [12:0] sad;
        logic [4:0]  pp;
        logic [2:0]  lane;
        s = 0;
        for (int b = 0; b < 16; b++) begin
            c = int'(cur_of(t, p, b));
            r = int'(ref_of(t, p, b, k));
            s += (c > r) ? c - r : r - c;
        end
        if (s > 8191) s = 8191;
        sad  = 13'(s);
        pp   = 5'(p);
        lane = 3'(k - 1);
        return {sad, pp[4:1], pp[0], lane};
    endfunction

    task automatic run_block(input int t, input bit stall,
                             input bit inject, input int ab_pass,
                             input int ab_beat, output int done_cyc);
        int cyc, bp, bb, works, dones, last_work;
        @(negedge clk);
        start_a = 1'b1;
        pa.in_valid = 1'b0;
        cyc = 0; bp = 0; bb = 0; works = 0; dones = 0;
        last_work = -100;
        done_cyc = -1;
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start_a = 1'b0;
            if (cyc == 1) chk("busy_rise", busy_a, 1);
            if (work_a) begin
                chk("work_per_16_beats", works, bp - 1);
                for (int k = 1; k <= 8; k++)
                    chk($sformatf("t%0d_p%0d_mad%0d", t, works, k),
                        mad_a[k], exp_mad(t, works, k));
                if (t == 1 && works == 5) begin
                    chk("hand_p5_lane4", mad_a[4], 21'h00002B);
                    chk("hand_p5_lane1", mad_a[1], 21'h001028);
                end
                works++;
                last_work = cyc;
            end
            if (cyc == last_work + 1 && works == 32)
                chk("mad_hold", mad_a[8], exp_mad(t, 31, 8));
            if (done_a) begin
                dones++;
                done_cyc = cyc;
                chk("done_eq_refresh", refr_a, 1);
                chk("refresh_gap", cyc - last_work, 5);
            end
            if (done_cyc > 0 && cyc == done_cyc + 1)
                chk("busy_fall", busy_a, 0);
            if (done_cyc > 0 && cyc == done_cyc + 4) break;
            if (bp == ab_pass && bb == ab_beat) begin
                reset = 1'b1;
                #1;
                chk("rst_busy", busy_a, 0);
                chk("rst_ready", pa.in_ready, 0);
                for (int k = 1; k <= 8; k++)
                    chk($sformatf("rst_mad%0d", k), mad_a[k], 21'h1FFFFF);
                return;
            end
            start_a = inject && (cyc == 5 || cyc == 546);
            pa.in_valid = stall ? (cyc % 2 == 1) : 1'b1;
            pa.cur_pix = cur_of(t, bp, bb);
            for (int k = 1; k <= 8; k++)
                pa.ref_pix[8*(k-1) +: 8] = ref_of(t, bp, bb, k);
            if (pa.in_valid && pa.in_ready) begin
                bb++;
                if (bb == 16) begin
                    bb = 0;
                    bp++;
                end
            end
        end
        if (done_cyc < 0) chk("timeout_a", 0, 1);
        chk($sformatf("t%0d_work_count", t), works, 32);
        chk($sformatf("t%0d_done_count", t), dones, 1);
    endtask

    int dc;
    int cyc_b, works_b;
    logic [4:0] pp;

    initial begin
        reset = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        pa.in_valid = 1'b0; pa.cur_pix = '0; pa.ref_pix = '0;
        pb.in_valid = 1'b0; pb.cur_pix = '0; pb.ref_pix = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_in_ready", pa.in_ready, 0);
        chk("rst_work", work_a, 0);
        chk("rst_refresh", refr_a, 0);
        chk("rst_mad1", mad_a[1], 21'h1FFFFF);
        chk("rst_mad8", mad_a[8], 21'h1FFFFF);
        reset = 1'b0;

        run_block(1, 1'b0, 1'b0, -1, -1, dc);
        chk("t1_start_to_done", dc, 549);
        run_block(3, 1'b1, 1'b0, -1, -1, dc);
        run_block(3, 1'b0, 1'b1, -1, -1, dc);
        chk("t3_inject_start_to_done", dc, 549);

        run_block(1, 1'b0, 1'b0, 3, 7, dc);
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_refresh", refr_a, 0);
            chk("rst_no_done", done_a, 0);
        end
        reset = 1'b0;
        run_block(1, 1'b0, 1'b0, -1, -1, dc);
        chk("after_rst_start_to_done", dc, 549);

        @(negedge clk);
        start_b = 1'b1;
        pb.in_valid = 1'b1;
        pb.cur_pix = 8'd255;
        pb.ref_pix = '0;
        cyc_b = 0;
        works_b = 0;
        while (cyc_b < 5000) begin
            @(negedge clk);
            cyc_b++;
            start_b = 1'b0;
            if (work_b) begin
                pp = 5'(works_b);
                for (int k = 1; k <= 8; k++) begin
                    chk($sformatf("sat_p%0d_sad%0d", works_b, k),
                        mad_b[k][20:8], 8191);
                    chk($sformatf("sat_p%0d_pos%0d", works_b, k),
                        mad_b[k][7:0], {pp[4:1], pp[0], 3'(k - 1)});
                end
                works_b++;
            end
            if (done_b) break;
        end
        chk("sat_done_seen", done_b, 1);
        chk("sat_start_to_done", cyc_b, 32 * 65 + 5);
        chk("sat_work_count", works_b, 32);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
